// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - button pins in, debounced levels and edge pulses out
interface button_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] db_out;
    logic [WIDTH-1:0] press_p;
    logic [WIDTH-1:0] release_p;
    logic [WIDTH-1:0] long_press;

    modport master (
        output raw_in,
        input  db_out,
        input  press_p,
        input  release_p,
        input  long_press
    );

    modport slave (
        input  raw_in,
        output db_out,
        output press_p,
        output release_p,
        output long_press
    );
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-bit synchroniser + stability-counter debouncer with press/release pulses
// Long-press detection is built only when BUTTON_DEBOUNCE_LONGPRESS_EN is defined.
module button_debounce #(
    parameter int   WIDTH      = 4,
    parameter int   CNT_W      = 20,
    parameter int   STABLE_CNT = 500000,
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   LONG_W     = 26,
    parameter int   LONG_CNT   = 50000000
) (
    input  logic                clk,
    input  logic                reset_n,
    button_debounce_if.slave    btn
);
    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(STABLE_CNT - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_db;
    logic [WIDTH-1:0] r_press;
    logic [WIDTH-1:0] r_release;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] w_accept;

    // A bit is pending (CHECK) whenever the synchronised level differs from db_out.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = (r_s2[i] != r_db[i]) && (r_cnt[i] == C_TERM);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1      <= {WIDTH{IDLE_LEVEL}};
            r_s2      <= {WIDTH{IDLE_LEVEL}};
            r_db      <= {WIDTH{IDLE_LEVEL}};
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= btn.raw_in;
            r_s2 <= r_s1;
            for (int i = 0; i < WIDTH; i++) begin
                r_press[i]   <= 1'b0;
                r_release[i] <= 1'b0;
                if (r_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_db[i]  <= r_s2[i];
                    r_cnt[i] <= '0;
                    if (r_s2[i] != IDLE_LEVEL) begin
                        r_press[i] <= 1'b1;
                    end else begin
                        r_release[i] <= 1'b1;
                    end
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn.db_out    = r_db;
    assign btn.press_p   = r_press;
    assign btn.release_p = r_release;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam logic [LONG_W-1:0] C_LONG     = LONG_W'(LONG_CNT);
    localparam logic [LONG_W-1:0] C_LONG_PRE = LONG_W'(LONG_CNT - 1);

    logic [LONG_W-1:0] r_hcnt [WIDTH];
    logic [WIDTH-1:0]  r_long;

    // A release accepted this clock wins over the hold count so the flag drops with release_p.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_long <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_hcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_accept[i] && (r_s2[i] == IDLE_LEVEL)) begin
                    r_hcnt[i] <= '0;
                    r_long[i] <= 1'b0;
                end else if (r_db[i] != IDLE_LEVEL) begin
                    if (r_hcnt[i] != C_LONG) begin
                        r_hcnt[i] <= r_hcnt[i] + 1'b1;
                    end
                    if (r_hcnt[i] == C_LONG_PRE) begin
                        r_long[i] <= 1'b1;
                    end
                end else begin
                    r_hcnt[i] <= '0;
                    r_long[i] <= 1'b0;
                end
            end
        end
    end

    assign btn.long_press = r_long;
`else
    assign btn.long_press = '0;
`endif
endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed table-driven bench for button_debounce
module tb_button_debounce;
    typedef struct {
        logic [3:0] raw;
        int         ncyc;
        logic [3:0] db;
        logic [3:0] press;
        logic [3:0] rel;
    } vec_t;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam logic [3:0] LP_BIT2 = 4'h4;
`else
    localparam logic [3:0] LP_BIT2 = 4'h0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    button_debounce_if #(.WIDTH(4)) btn ();

    button_debounce #(
        .WIDTH(4), .CNT_W(20), .STABLE_CNT(8), .IDLE_LEVEL(1'b1),
        .LONG_W(26), .LONG_CNT(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn(btn)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] raw, input int ncyc, input logic [3:0] db,
                                input logic [3:0] press, input logic [3:0] rel);
        vec_t v;
        v.raw = raw; v.ncyc = ncyc; v.db = db; v.press = press; v.rel = rel;
        return v;
    endfunction

    initial begin
        int np, nr, early;
        logic [3:0] lvl;

        tbl.push_back(mk(4'hF, 12, 4'hF, 4'h0, 4'h0));
        tbl.push_back(mk(4'hE,  9, 4'hF, 4'h0, 4'h0));
        tbl.push_back(mk(4'hE,  1, 4'hE, 4'h1, 4'h0));
        tbl.push_back(mk(4'hE,  1, 4'hE, 4'h0, 4'h0));
        tbl.push_back(mk(4'hF,  9, 4'hE, 4'h0, 4'h0));
        tbl.push_back(mk(4'hF,  1, 4'hF, 4'h0, 4'h1));
        tbl.push_back(mk(4'hF,  1, 4'hF, 4'h0, 4'h0));
        tbl.push_back(mk(4'hE,  7, 4'hF, 4'h0, 4'h0));
        tbl.push_back(mk(4'hF, 12, 4'hF, 4'h0, 4'h0));
        tbl.push_back(mk(4'hE,  8, 4'hF, 4'h0, 4'h0));
        tbl.push_back(mk(4'hF,  2, 4'hE, 4'h1, 4'h0));
        tbl.push_back(mk(4'hF,  7, 4'hE, 4'h0, 4'h0));
        tbl.push_back(mk(4'hF,  1, 4'hF, 4'h0, 4'h1));
        tbl.push_back(mk(4'h5,  9, 4'hF, 4'h0, 4'h0));
        tbl.push_back(mk(4'h5,  1, 4'h5, 4'hA, 4'h0));
        tbl.push_back(mk(4'h5,  1, 4'h5, 4'h0, 4'h0));
        tbl.push_back(mk(4'h5, 10, 4'h5, 4'h0, 4'h0));
        tbl.push_back(mk(4'hF,  9, 4'h5, 4'h0, 4'h0));
        tbl.push_back(mk(4'hF,  1, 4'hF, 4'h0, 4'hA));
        tbl.push_back(mk(4'hF,  1, 4'hF, 4'h0, 4'h0));

        // reset with all pins low
        btn.raw_in = 4'h0;
        reset_n = 1'b0;
        step(3);
        chk("rst_db", btn.db_out, 4'hF);
        chk("rst_press", btn.press_p, 4'h0);
        chk("rst_release", btn.release_p, 4'h0);
        chk("rst_long", btn.long_press, 4'h0);
        reset_n = 1'b1;
        step(1);
        chk("post_rst_db", btn.db_out, 4'hF);
        chk("post_rst_press", btn.press_p, 4'h0);
        chk("post_rst_release", btn.release_p, 4'h0);
        btn.raw_in = 4'hF;
        step(15);
        chk("settle_db", btn.db_out, 4'hF);

        for (int i = 0; i < tbl.size(); i++) begin
            btn.raw_in = tbl[i].raw;
            step(tbl[i].ncyc);
            chk($sformatf("vec%0d_db", i), btn.db_out, tbl[i].db);
            chk($sformatf("vec%0d_press", i), btn.press_p, tbl[i].press);
            chk($sformatf("vec%0d_release", i), btn.release_p, tbl[i].rel);
            chk($sformatf("vec%0d_long", i), btn.long_press, 4'h0);
        end

        // bit 1 bounces every 3 clocks, then settles low
        np = 0; nr = 0; early = 0;
        for (int k = 0; k < 14; k++) begin
            btn.raw_in = (k % 2 == 0) ? 4'hD : 4'hF;
            for (int j = 0; j < 3; j++) begin
                step(1);
                if (btn.press_p[1]) np++;
                if (btn.release_p[1]) nr++;
                if (!btn.db_out[1]) early++;
            end
        end
        btn.raw_in = 4'hD;
        for (int j = 1; j <= 10; j++) begin
            step(1);
            if (btn.press_p[1]) np++;
            if (btn.release_p[1]) nr++;
            if (j == 9) chk("bounce_db_before", btn.db_out, 4'hF);
            if (j == 10) chk("bounce_db_after", btn.db_out, 4'hD);
        end
        chk("bounce_early_changes", 4'(early), 4'h0);
        chk("bounce_press_count", 4'(np), 4'h1);
        chk("bounce_release_count", 4'(nr), 4'h0);
        btn.raw_in = 4'hF;
        step(12);
        chk("bounce_restore_db", btn.db_out, 4'hF);

        // reset in the middle of a pending press
        btn.raw_in = 4'hE;
        step(7);
        reset_n = 1'b0;
        #1;
        chk("midrst_db_now", btn.db_out, 4'hF);
        step(2);
        chk("midrst_db_held", btn.db_out, 4'hF);
        reset_n = 1'b1;
        step(9);
        chk("midrst_db_pre", btn.db_out, 4'hF);
        step(1);
        chk("midrst_db_accept", btn.db_out, 4'hE);
        chk("midrst_press", btn.press_p, 4'h1);
        btn.raw_in = 4'hF;
        step(12);
        chk("midrst_restore_db", btn.db_out, 4'hF);

        // long press on bit 2
        btn.raw_in = 4'hB;
        step(10);
        chk("long_fall_db", btn.db_out, 4'hB);
        chk("long_fall_press", btn.press_p, 4'h4);
        step(31);
        chk("long_before", btn.long_press, 4'h0);
        step(1);
        chk("long_set", btn.long_press, LP_BIT2);
        btn.raw_in = 4'hF;
        step(9);
        lvl = btn.long_press;
        chk("long_held", lvl, LP_BIT2);
        step(1);
        chk("long_clear", btn.long_press, 4'h0);
        chk("long_release_p", btn.release_p, 4'h4);
        chk("long_release_db", btn.db_out, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
